cordic_atan_rom: RTL and testbench

- Constant lookup table of CORDIC elementary rotation angles: entry i = atan(2^-i) radians.
- 32 entries, signed fixed point, 2 integer bits (incl. sign) and 30 fractional bits (Q2.30).
- Feeds the CORDIC iteration datapath.
- Provides a combinational read port, plus a registered copy with a valid flag for pipelined consumers.

---
 rtl/cordic_atan_rom.sv | 46 ++++
 tb/tb_cordic_atan_rom.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: Q2.30 atan(2^-i) table, comb + registered read; ROM_PARITY_EN adds parity/parity_q
module cordic_atan_rom (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  address,
  input  logic        en,
  output logic [31:0] data,
  output logic [31:0] data_q,
`ifdef ROM_PARITY_EN
  output logic        parity,
  output logic        parity_q,
`endif
  output logic        valid_q
);
  always_comb begin
    case (address)
      5'd0:    data = 32'h3243F6A8;
      5'd1:    data = 32'h1DAC6705;
      5'd2:    data = 32'h0FADBAFC;
      5'd3:    data = 32'h07F56EA6;
      5'd4:    data = 32'h03FEAB76;
      5'd5:    data = 32'h01FFD55B;
      5'd6:    data = 32'h00FFFAAA;
      5'd7:    data = 32'h007FFF55;
      5'd8:    data = 32'h003FFFEA;
      5'd9:    data = 32'h001FFFFD;
      default: data = (address == 5'd31) ? 32'd0 : (32'd1 << (5'd30 - address)) - 32'd1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) data_q <= data;
    end
  end
`ifdef ROM_PARITY_EN
  assign parity = ^data;
  always_ff @(posedge clk) begin
    if (!rst_n) parity_q <= 1'b0;
    else if (en) parity_q <= parity;
  end
`endif
endmodule

// File: tb/tb_cordic_atan_rom.sv
// tb_cordic_atan_rom: scoreboard bench for the atan ROM comb and registered ports
module tb_cordic_atan_rom;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  address;
  logic        en;
  logic [31:0] data;
  logic [31:0] data_q;
  logic        valid_q;
`ifdef ROM_PARITY_EN
  logic        parity;
  logic        parity_q;
`endif
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] tbl [32];
  logic [31:0] mq;
  logic        mv;
  logic        mp;
  logic [33:0] sb [$];

  cordic_atan_rom dut (
    .clk(clk),
    .rst_n(rst_n),
    .address(address),
    .en(en),
    .data(data),
    .data_q(data_q),
`ifdef ROM_PARITY_EN
    .parity(parity),
    .parity_q(parity_q),
`endif
    .valid_q(valid_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [4:0] a);
    logic [33:0] x;
    @(negedge clk);
    rst_n = r;
    en = e;
    address = a;
    if (!r) begin
      mq = '0;
      mv = 1'b0;
      mp = 1'b0;
    end else if (e) begin
      mq = tbl[a];
      mv = 1'b1;
      mp = ^tbl[a];
    end else begin
      mv = 1'b0;
    end
    sb.push_back({mp, mv, mq});
    @(posedge clk);
    #1;
    check("data_comb", data, tbl[a]);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      x = sb.pop_front();
      check("data_q", data_q, x[31:0]);
      check("valid_q", {31'b0, valid_q}, {31'b0, x[32]});
`ifdef ROM_PARITY_EN
      check("parity_q", {31'b0, parity_q}, {31'b0, x[33]});
      check("parity", {31'b0, parity}, {31'b0, ^tbl[a]});
`endif
    end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = 32'h3243F6A8; tbl[1] = 32'h1DAC6705; tbl[2] = 32'h0FADBAFC;
    tbl[3] = 32'h07F56EA6; tbl[4] = 32'h03FEAB76; tbl[5] = 32'h01FFD55B;
    tbl[6] = 32'h00FFFAAA; tbl[7] = 32'h007FFF55; tbl[8] = 32'h003FFFEA;
    tbl[9] = 32'h001FFFFD;
    for (int i = 10; i < 30; i++) tbl[i] = 32'((64'd1 << (30 - i)) - 64'd1);
    tbl[30] = 32'h0;
    tbl[31] = 32'h0;
    mq = '0; mv = 1'b0; mp = 1'b0;
    rst_n = 1'b0;
    en = 1'b1;
    address = '0;
    for (int i = 0; i < 32; i++) begin
      address = 5'(i);
      #1;
      check($sformatf("rom[%0d]", i), data, tbl[i]);
    end
    check("spot_20", tbl[20], 32'h000003FF);
    check("spot_10", tbl[10], 32'h000FFFFF);
    check("spot_29", tbl[29], 32'h00000001);
    step(1'b0, 1'b1, 5'd0);
    step(1'b0, 1'b1, 5'd0);
    step(1'b1, 1'b1, 5'd1);
    step(1'b1, 1'b1, 5'd2);
    step(1'b1, 1'b1, 5'd3);
    step(1'b1, 1'b1, 5'd9);
    step(1'b1, 1'b0, 5'd9);
    step(1'b1, 1'b0, 5'd4);
    step(1'b1, 1'b1, 5'd5);
    step(1'b0, 1'b1, 5'd5);
    step(1'b1, 1'b1, 5'd5);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 5'(31 - i));
    for (int i = 0; i < 16; i++) step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    step(1'b1, 1'b1, 5'd0);
    step(1'b1, 1'b1, 5'd31);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
